control_unit: RTL and testbench

//  RV32I single-cycle control unit: main decoder + ALU decoder in one block.

---
 rtl/control_pkg.sv | 39 +++
 rtl/alu_decoder.sv | 39 +++
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the RV32I control unit: opcodes, func7 patterns and the
// immediate-type, ALU-control and ALU-op enumerations.
package control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_type_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_RSVD = 3'b111
  } alu_control_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the main decoder's alu_op plus func3/func7[5] onto an ALU
// operation, flagging func3 codes the ALU does not implement (shifts).
module alu_decoder
  import control_pkg::*;
(
  input  alu_op_e      alu_op,
  input  logic [2:0]   func3,
  input  logic         func7_b5,
  input  logic         is_rtype,
  output alu_control_e alu_control,
  output logic         funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (func3)
          // Immediate forms have no SUB; func7 there is part of the immediate.
          3'b000:  alu_control = (is_rtype && func7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: begin
            alu_control   = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I single-cycle control unit: main decoder, branch resolution and a sticky
// illegal-instruction flag. Define CONTROL_ITYPE_ALU_EN to decode I-type ALU ops.
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       reg_write,
  output logic       mem_write,
  output logic       alu_source,
  output logic       result_source,
  output logic [2:0] imm_type,
  output logic [2:0] alu_control,
  output logic       pc_source,
  output logic       illegal_instr,
  output logic       illegal_sticky
);

  logic         reg_write_main;
  logic         is_rtype;
  logic         is_branch;
  logic         decode_illegal;
  imm_type_e    imm_sel;
  alu_op_e      alu_op;
  alu_control_e alu_ctrl_dec;
  alu_control_e alu_ctrl_fin;
  logic         funct_illegal;
  logic         func7_illegal;
  logic         branch_illegal;
  logic         illegal_sticky_d;
  logic         illegal_sticky_q;

  always_comb begin
    reg_write_main = 1'b0;
    mem_write      = 1'b0;
    alu_source     = 1'b0;
    result_source  = 1'b0;
    imm_sel        = IMM_I;
    alu_op         = ALUOP_ADD;
    is_rtype       = 1'b0;
    is_branch      = 1'b0;
    decode_illegal = 1'b0;
    case (op_code)
      OP_LOAD: begin
        reg_write_main = 1'b1;
        alu_source     = 1'b1;
        result_source  = 1'b1;
      end
      OP_STORE: begin
        mem_write  = 1'b1;
        alu_source = 1'b1;
        imm_sel    = IMM_S;
      end
      OP_RTYPE: begin
        reg_write_main = 1'b1;
        alu_op         = ALUOP_FUNCT;
        is_rtype       = 1'b1;
      end
`ifdef CONTROL_ITYPE_ALU_EN
      OP_ITYPE: begin
        reg_write_main = 1'b1;
        alu_source     = 1'b1;
        alu_op         = ALUOP_FUNCT;
      end
`else
      OP_ITYPE: decode_illegal = 1'b1;
`endif
      OP_BRANCH: begin
        imm_sel   = IMM_B;
        alu_op    = ALUOP_SUB;
        is_branch = 1'b1;
      end
      default: decode_illegal = 1'b1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .func3         (func3),
    .func7_b5      (func7[5]),
    .is_rtype      (is_rtype),
    .alu_control   (alu_ctrl_dec),
    .funct_illegal (funct_illegal)
  );

  // The alternate func7 pattern is only meaningful for SUB.
  always_comb begin
    func7_illegal = is_rtype &&
                    !((func7 == F7_BASE) || ((func7 == F7_ALT) && (func3 == 3'b000)));
    alu_ctrl_fin  = (funct_illegal || func7_illegal) ? ALU_ADD : alu_ctrl_dec;
  end

  always_comb begin
    pc_source      = 1'b0;
    branch_illegal = 1'b0;
    if (is_branch) begin
      case (func3)
        3'b000:  pc_source = zero;
        3'b001:  pc_source = ~zero;
        default: branch_illegal = 1'b1;
      endcase
    end
  end

  assign reg_write     = reg_write_main & ~funct_illegal & ~func7_illegal;
  assign imm_type      = imm_sel;
  assign alu_control   = alu_ctrl_fin;
  assign illegal_instr = decode_illegal | funct_illegal | func7_illegal | branch_illegal;

  assign illegal_sticky_d = illegal_sticky_q | illegal_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_sticky_q <= 1'b0;
    else        illegal_sticky_q <= illegal_sticky_d;
  end

  assign illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed decode scenarios, sticky-flag behaviour
// and randomized instructions compared with a table-driven reference model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op_code = 7'b0;
  logic [2:0] func3 = 3'b0;
  logic [6:0] func7 = 7'b0;
  logic       zero = 1'b0;
  logic       reg_write, mem_write, alu_source, result_source;
  logic [2:0] imm_type, alu_control;
  logic       pc_source, illegal_instr, illegal_sticky;

  int checks = 0;
  int failures = 0;
  logic exp_sticky = 1'b0;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic       as;
    logic       rs;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       pc;
    logic       ill;
  } ctl_t;

  always #5 clk = ~clk;

  control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .op_code        (op_code),
    .func3          (func3),
    .func7          (func7),
    .zero           (zero),
    .reg_write      (reg_write),
    .mem_write      (mem_write),
    .alu_source     (alu_source),
    .result_source  (result_source),
    .imm_type       (imm_type),
    .alu_control    (alu_control),
    .pc_source      (pc_source),
    .illegal_instr  (illegal_instr),
    .illegal_sticky (illegal_sticky)
  );

  // Reference decode, written straight from the instruction tables.
  function automatic ctl_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z);
    ctl_t e;
    bit   funct;
    bit   rtype;
    e = '0;
    funct = 0;
    rtype = 0;
    case (op)
      7'b0000011: begin e.rw = 1; e.as = 1; e.rs = 1; end
      7'b0100011: begin e.mw = 1; e.as = 1; e.imm = 3'b001; end
      7'b0110011: begin e.rw = 1; funct = 1; rtype = 1; end
`ifdef CONTROL_ITYPE_ALU_EN
      7'b0010011: begin e.rw = 1; e.as = 1; funct = 1; end
`endif
      7'b1100011: begin
        e.imm = 3'b010;
        e.alu = 3'b001;
        if (f3 == 3'b000)      e.pc = z;
        else if (f3 == 3'b001) e.pc = !z;
        else                   e.ill = 1;
      end
      default: e.ill = 1;
    endcase
    if (funct) begin
      if (rtype && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000))) begin
        e.ill = 1; e.rw = 0; e.alu = 3'b000;
      end else begin
        case (f3)
          3'b000: e.alu = (rtype && f7 == 7'h20) ? 3'b001 : 3'b000;
          3'b010: e.alu = 3'b101;
          3'b011: e.alu = 3'b110;
          3'b100: e.alu = 3'b100;
          3'b110: e.alu = 3'b011;
          3'b111: e.alu = 3'b010;
          default: begin e.ill = 1; e.rw = 0; e.alu = 3'b000; end
        endcase
      end
    end
    return e;
  endfunction

  function automatic ctl_t observe();
    ctl_t o;
    o.rw  = reg_write;
    o.mw  = mem_write;
    o.as  = alu_source;
    o.rs  = result_source;
    o.imm = imm_type;
    o.alu = alu_control;
    o.pc  = pc_source;
    o.ill = illegal_instr;
    return o;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic z);
    @(negedge clk);
    op_code = op; func3 = f3; func7 = f7; zero = z;
    #1;
  endtask

  task automatic test_reset();
    ctl_t got;
    ctl_t exp;
    drive(7'b0000011, 3'b010, 7'h00, 1'b0);
    exp = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    got = observe();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_comb got=%h expected=%h", got, exp);
    end
    checks++;
    if (illegal_sticky !== 1'b0) begin
      failures++; $display("FAIL reset_sticky got=%b expected=0", illegal_sticky);
    end
    drive(7'b0000000, 3'b000, 7'h00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (illegal_instr !== 1'b1 || illegal_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold ill=%b sticky=%b expected ill=1 sticky=0", illegal_instr, illegal_sticky);
    end
    drive(7'b0000011, 3'b010, 7'h00, 1'b0);
    rst_n = 1'b1;
    exp_sticky = 1'b0;
  endtask

  task automatic test_load_store();
    ctl_t got;
    ctl_t exp;
    drive(7'b0100011, 3'b010, 7'h7f, 1'b1);
    exp = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0};
    got = observe();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL store got=%h expected=%h", got, exp);
    end
    drive(7'b0000011, 3'b111, 7'h55, 1'b1);
    exp = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
    got = observe();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL load got=%h expected=%h", got, exp);
    end
  endtask

  task automatic test_rtype();
    logic [2:0] f3s [5] = '{3'b000, 3'b111, 3'b110, 3'b000, 3'b001};
    logic [6:0] f7s [5] = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
    logic [2:0] alus[5] = '{3'b000, 3'b010, 3'b011, 3'b001, 3'b000};
    logic       rws [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ills[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ctl_t got;
    ctl_t exp;
    for (int i = 0; i < 5; i++) begin
      drive(7'b0110011, f3s[i], f7s[i], 1'b1);
      exp = '{rws[i], 1'b0, 1'b0, 1'b0, 3'b000, alus[i], 1'b0, ills[i]};
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL rtype_%0d got=%h expected=%h", i, got, exp);
      end
    end
    drive(7'b0110011, 3'b111, 7'h20, 1'b0);
    checks++;
    if (illegal_instr !== 1'b1 || reg_write !== 1'b0) begin
      failures++;
      $display("FAIL rtype_alt_and ill=%b rw=%b expected ill=1 rw=0", illegal_instr, reg_write);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s[5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    logic       zs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       pcs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ils[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ctl_t got;
    ctl_t exp;
    for (int i = 0; i < 5; i++) begin
      drive(7'b1100011, f3s[i], 7'h00, zs[i]);
      exp = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b001, pcs[i], ils[i]};
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL branch_%0d got=%h expected=%h", i, got, exp);
      end
    end
    drive(7'b0110011, 3'b000, 7'h00, 1'b1);
    checks++;
    if (pc_source !== 1'b0) begin
      failures++; $display("FAIL nonbranch_pc got=%b expected=0", pc_source);
    end
    exp_sticky = 1'b1;
  endtask

  task automatic test_illegal_sticky();
    ctl_t got;
    ctl_t exp;
    rst_n = 1'b0;
    drive(7'b0000011, 3'b000, 7'h00, 1'b0);
    rst_n = 1'b1;
    drive(7'b0000000, 3'b000, 7'h00, 1'b1);
    exp = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};
    got = observe();
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL illegal_row got=%h expected=%h", got, exp);
    end
    checks++;
    if (illegal_sticky !== 1'b0) begin
      failures++; $display("FAIL sticky_before_edge got=%b expected=0", illegal_sticky);
    end
    @(posedge clk); #1;
    checks++;
    if (illegal_sticky !== 1'b1) begin
      failures++; $display("FAIL sticky_set got=%b expected=1", illegal_sticky);
    end
    drive(7'b0000011, 3'b000, 7'h00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (illegal_sticky !== 1'b1) begin
      failures++; $display("FAIL sticky_hold got=%b expected=1", illegal_sticky);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (illegal_sticky !== 1'b0) begin
      failures++; $display("FAIL sticky_async_clear got=%b expected=0", illegal_sticky);
    end
    checks++;
    if (reg_write !== 1'b1 || result_source !== 1'b1) begin
      failures++; $display("FAIL comb_in_reset rw=%b rs=%b expected 1 1", reg_write, result_source);
    end
    drive(7'b0000011, 3'b000, 7'h00, 1'b0);
    rst_n = 1'b1;
    exp_sticky = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] ops[5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       z;
    ctl_t got;
    ctl_t exp;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       op = 7'($urandom);
        1, 2:    op = 7'b0110011;
        default: op = ops[$urandom_range(0, 4)];
      endcase
      case ($urandom_range(0, 3))
        0:       f7 = 7'($urandom);
        1:       f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      f3 = 3'($urandom);
      z  = 1'($urandom);
      if (i < 4) begin
        op = 7'b0000011; f3 = 3'($urandom);
      end
      drive(op, f3, f7, z);
      exp = model(op, f3, f7, z);
      got = observe();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_%0d op=%b f3=%b f7=%b z=%b got=%h expected=%h", i, op, f3, f7, z, got, exp);
      end
      @(posedge clk);
      exp_sticky = exp_sticky | exp.ill;
      #1;
      checks++;
      if (illegal_sticky !== exp_sticky) begin
        failures++;
        $display("FAIL random_sticky_%0d got=%b expected=%b", i, illegal_sticky, exp_sticky);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_rtype();
    test_branch();
    test_illegal_sticky();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
